turbo_sched: RTL and testbench

Turbo-mode scheduler between the user turbo setting and the CPU clock generator. Resolves the requested CPU speed from the menu request and a set of force-normal-speed requesters (tape, beeper, timing-critical peripherals), with a frame-based hold-off. Commits a speed change only at an opcode-fetch boundary, freezing the CPU clock around the switch. Its `turbo` output drives the clock generator's turbo select; its `stop` output is ORed into the generator's clock-wait term.

---
 rtl/turbo_sched_if.sv | 30 +++
 rtl/turbo_sched.sv | 135 +++++++++++++
 tb/tb_turbo_sched.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/turbo_sched_if.sv
// Bundle of CPU-side status, speed requests and clock-generator controls for turbo_sched.
// Plain wires with no state, so there is no added latency.
// No backpressure: the inputs are levels or pulses, and `stop` is the only way the scheduler holds the CPU.
interface turbo_sched_if #(
  parameter int NFORCE = 4
);
  logic              clkcpu_ck;
  logic              m1;
  logic              mreq;
  logic              cpu_in_reset;
  logic              frame_tick;
  logic [1:0]        turbo_req;
  logic [NFORCE-1:0] force_none;
  logic [1:0]        turbo;
  logic              stop;
  logic              busy;
  logic              switch_done;

  // System side: supplies requests and CPU status, and consumes the speed select.
  modport master (
    output clkcpu_ck, m1, mreq, cpu_in_reset, frame_tick, turbo_req, force_none,
    input  turbo, stop, busy, switch_done
  );

  // Scheduler side.
  modport slave (
    input  clkcpu_ck, m1, mreq, cpu_in_reset, frame_tick, turbo_req, force_none,
    output turbo, stop, busy, switch_done
  );
endinterface

// File: rtl/turbo_sched.sv
// Turbo scheduler: resolves the CPU speed from the user request, the force requesters and the frame hold-off, then commits it at an M1 fetch.
// Latency: 1 cycle from a target change to busy. A qualifying M1 clkcpu_ck commits the new turbo 3 cycles later, and stop falls SETTLE_CYC cycles after that.
// No backpressure: stop is asserted for the whole STOP+SWITCH window so the clock generator freezes the CPU clock.
module turbo_sched #(
  parameter int NFORCE      = 4,
  parameter int HOLD_FRAMES = 3,
  parameter int SETTLE_CYC  = 4,
  parameter int ARM_TIMEOUT = 1023
) (
  input  logic          clk28,
  input  logic          rst,
  turbo_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, STOP, SWITCH} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES);
  localparam logic [9:0] ARM_LIM   = 10'(ARM_TIMEOUT);
  localparam logic [9:0] SET_LAST  = 10'(SETTLE_CYC - 1);
  localparam logic [9:0] STOP_LAST = 10'd1;

  state_t            state_q, state_d;
  logic [3:0]        hold_q;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        turbo_q, turbo_d;
  logic [9:0]        cnt_q, cnt_d;
  logic              done_d;
  logic              stop_q, busy_q, done_q;
  logic [NFORCE-1:0] force_vec;
  logic              any_force;
  logic [1:0]        req_map;
  logic [1:0]        target;
  logic              arm_fire;

  assign force_vec = bus.force_none;
  assign any_force = |force_vec;
  assign req_map   = (bus.turbo_req == 2'd3) ? 2'd0 : bus.turbo_req;
  // Normal speed wins while a requester is active, and keeps winning until the hold-off frames have elapsed.
  assign target    = (any_force || (hold_q != 4'd0)) ? 2'd0 : req_map;
  assign arm_fire  = (bus.clkcpu_ck && bus.m1 && bus.mreq) || (cnt_q == ARM_LIM) || bus.cpu_in_reset;

  // Hold-off counter: reloaded while any force is active (reload beats frame_tick), otherwise counts frames down to 0.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      hold_q <= 4'd0;
    end else if (any_force) begin
      hold_q <= HOLD_INIT;
    end else if (bus.frame_tick && (hold_q != 4'd0)) begin
      hold_q <= hold_q - 4'd1;
    end
  end

  // State, pending speed, shared cycle counter and registered outputs.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 2'd0;
      turbo_q <= 2'd0;
      cnt_q   <= 10'd0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      turbo_q <= turbo_d;
      cnt_q   <= cnt_d;
      stop_q  <= (state_d == STOP) || (state_d == SWITCH);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  // Next state: arm on a target change, freeze at the fetch boundary, commit on SWITCH entry, then let the clock settle.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    turbo_d = turbo_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (target != turbo_q) begin
          pend_d = target;
          cnt_d  = 10'd0;
          if (bus.cpu_in_reset) begin
            // The CPU is not executing, so there is no fetch boundary to wait for.
            state_d = SWITCH;
            turbo_d = target;
            done_d  = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (target == turbo_q) begin
          state_d = IDLE;
        end else begin
          pend_d = target;
          cnt_d  = cnt_q + 10'd1;
          if (arm_fire) begin
            state_d = STOP;
            cnt_d   = 10'd0;
          end
        end
      end
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          state_d = SWITCH;
          cnt_d   = 10'd0;
          turbo_d = pend_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      SWITCH: begin
        if (cnt_q == SET_LAST) begin
          state_d = IDLE;
          cnt_d   = 10'd0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.turbo       = turbo_q;
  assign bus.stop        = stop_q;
  assign bus.busy        = busy_q;
  assign bus.switch_done = done_q;

endmodule

// File: tb/tb_turbo_sched.sv
// Self-checking bench for turbo_sched: reset values, a vector table, directed corner cases, and random traffic against a timeline model.
// Inputs are driven 1 time unit after posedge, and outputs are sampled at negedge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_turbo_sched;
  localparam int NF     = 4;
  localparam int HOLD   = 3;
  localparam int SETTLE = 4;
  localparam int ATO    = 20;

  logic clk28 = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk28 = ~clk28;
  always @(posedge clk28) cyc <= cyc + 1;

  turbo_sched_if #(.NFORCE(NF)) bus ();

  turbo_sched #(.NFORCE(NF), .HOLD_FRAMES(HOLD), .SETTLE_CYC(SETTLE), .ARM_TIMEOUT(ATO)) dut (
    .clk28 (clk28),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]    req;
    logic [NF-1:0] frc;
    logic          ck;
    logic          tick;
    logic [1:0]    e_turbo;
    logic          e_stop;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input int req, input int frc, input int ck, input int tick,
                              input int et, input int es, input int eb, input int ed);
    vec_t v;
    v.req = 2'(req); v.frc = NF'(frc); v.ck = 1'(ck); v.tick = 1'(tick);
    v.e_turbo = 2'(et); v.e_stop = 1'(es); v.e_busy = 1'(eb); v.e_done = 1'(ed);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [NF-1:0] frc, input logic ck,
                       input logic m1, input logic mreq, input logic crst, input logic tick);
    bus.turbo_req    = req;
    bus.force_none   = frc;
    bus.clkcpu_ck    = ck;
    bus.m1           = m1;
    bus.mreq         = mreq;
    bus.cpu_in_reset = crst;
    bus.frame_tick   = tick;
  endtask

  task automatic nxt();
    @(posedge clk28);
    #1;
  endtask

  task automatic mid();
    @(negedge clk28);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_turbo"}, bus.turbo, 0);
    chk({tag, "_stop"},  bus.stop, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.switch_done, 0);
  endtask

  task automatic do_reset();
    drive(2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    mid();
    chk_zero("reset");
    nxt();
    rst = 1'b0;
  endtask

  // which: 0 busy high, 1 stop high, 2 switch_done high, 3 stop low. Returns at the negedge of the hit cycle.
  task automatic wait_sig(input string name, input int which, input int limit, output int t);
    bit hit;
    hit = 1'b0;
    t = -1;
    for (int i = 0; i < limit && !hit; i++) begin
      mid();
      case (which)
        0: hit = bus.busy;
        1: hit = bus.stop;
        2: hit = bus.switch_done;
        default: hit = !bus.stop;
      endcase
      if (hit) t = cyc;
      else nxt();
    end
    chk({name, "_seen"}, int'(hit), 1);
  endtask

  // Timeline model state.
  int m_turbo, m_cval, m_commit, m_fz_start, m_fz_end, m_arm_start, m_fs;
  bit m_armed;

  initial begin
    int t_arm, t_stop, t_done, t_fall, t_m, tgt;
    bit exp_stop;
    logic [1:0] r_req;
    logic [NF-1:0] r_frc;
    logic r_ck, r_m1, r_mreq, r_crst, r_tick;

    // ---------------- reset and vector table ----------------
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(2, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(2, 0, 1, 0, 0, 0, 1, 0);
    tbl[6]  = mk(2, 0, 0, 0, 0, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 2, 1, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 2, 1, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 2, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 2, 1, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 2, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 2, 0, 1, 0);
    tbl[14] = mk(2, 2, 0, 1, 2, 0, 1, 0);
    tbl[15] = mk(2, 0, 1, 0, 2, 0, 1, 0);
    tbl[16] = mk(2, 0, 0, 0, 2, 1, 1, 0);
    tbl[17] = mk(2, 0, 0, 0, 2, 1, 1, 0);
    tbl[18] = mk(2, 0, 0, 0, 0, 1, 1, 1);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].req, tbl[i].frc, tbl[i].ck, tbl[i].ck, tbl[i].ck, 1'b0, tbl[i].tick);
      mid();
      chk($sformatf("tbl%0d_turbo", i), bus.turbo, tbl[i].e_turbo);
      chk($sformatf("tbl%0d_stop", i),  bus.stop, tbl[i].e_stop);
      chk($sformatf("tbl%0d_busy", i),  bus.busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i),  bus.switch_done, tbl[i].e_done);
      nxt();
    end

    // ---------------- timeout with no M1 ----------------
    do_reset();
    drive(2'd1, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_sig("to_arm", 0, 5, t_arm);
    nxt();
    wait_sig("to_stop", 1, 60, t_stop);
    chk("to_stop_latency", t_stop - t_arm, ATO + 1);
    nxt();
    wait_sig("to_done", 2, 10, t_done);
    chk("to_done_latency", t_done - t_stop, 2);
    chk("to_turbo", bus.turbo, 1);

    // ---------------- CPU held in reset: switch straight from IDLE ----------------
    do_reset();
    drive(2'd2, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mid();
    chk("cpurst_idle_busy", bus.busy, 0);
    nxt();
    mid();
    chk("cpurst_busy", bus.busy, 1);
    nxt();
    mid();
    chk("cpurst_turbo", bus.turbo, 2);
    chk("cpurst_stop", bus.stop, 1);

    // ---------------- reset asserted mid-switch ----------------
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    nxt();
    rst = 1'b0;
    drive(2'd2, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_sig("rearm", 0, 5, t_arm);
    nxt();
    drive(2'd2, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    t_m = cyc;
    mid();
    chk("m1_stop_before", bus.stop, 0);
    nxt();
    drive(2'd2, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_sig("m1_done", 2, 10, t_done);
    chk("m1_done_latency", t_done - t_m, 3);
    chk("m1_turbo", bus.turbo, 2);
    chk("m1_stop_in_switch", bus.stop, 1);
    nxt();
    wait_sig("m1_stopfall", 3, 20, t_fall);
    chk("m1_stopfall_latency", t_fall - t_m, 3 + SETTLE);
    chk("m1_busy_after", bus.busy, 0);

    // ---------------- force requester and frame hold-off ----------------
    for (int k = 0; k < 108; k++) begin
      nxt();
      drive(2'd2, (k < 10) ? NF'(2) : NF'(0), 1'((k % 8) == 7), 1'b1, 1'b1, 1'b0,
            1'(k == 9 || k == 40 || k == 70 || k == 100));
      mid();
      if (k == 0)   chk("hold_busy_k0", bus.busy, 0);
      if (k == 1)   chk("hold_busy_k1", bus.busy, 1);
      if (k == 30)  chk("hold_turbo_forced", bus.turbo, 0);
      if (k == 99)  chk("hold_turbo_2ticks", bus.turbo, 0);
      if (k == 101) chk("hold_busy_k101", bus.busy, 0);
      if (k == 102) chk("hold_busy_k102", bus.busy, 1);
      if (k == 105) chk("hold_turbo_k105", bus.turbo, 0);
      if (k == 106) begin
        chk("hold_turbo_back", bus.turbo, 2);
        chk("hold_done_back", bus.switch_done, 1);
      end
    end
    nxt();

    // ---------------- random traffic against a timeline model ----------------
    do_reset();
    m_turbo = 0; m_cval = 0; m_commit = -1; m_fz_start = 0; m_fz_end = 0;
    m_arm_start = 0; m_fs = HOLD; m_armed = 1'b0;
    r_req = 2'd0; r_frc = '0; r_crst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) r_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) r_frc[$urandom_range(0, NF - 1)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) r_frc = '0;
      if ($urandom_range(0, 299) == 0) r_crst = ~r_crst;
      r_tick = ($urandom_range(0, 24) == 0);
      r_ck   = ($urandom_range(0, 5) == 0);
      r_m1   = ($urandom_range(0, 1) == 0);
      r_mreq = ($urandom_range(0, 2) != 0);
      drive(r_req, r_frc, r_ck, r_m1, r_mreq, r_crst, r_tick);
      mid();
      if (c == m_commit) m_turbo = m_cval;
      exp_stop = (c >= m_fz_start) && (c < m_fz_end);
      chk("rnd_turbo", bus.turbo, m_turbo);
      chk("rnd_stop",  bus.stop, int'(exp_stop));
      chk("rnd_busy",  bus.busy, int'(m_armed || exp_stop));
      chk("rnd_done",  bus.switch_done, int'(c == m_commit));
      // Speed the scheduler should aim for this cycle.
      tgt = (r_frc != '0 || m_fs < HOLD) ? 0 : ((r_req == 2'd3) ? 0 : int'(r_req));
      if (!exp_stop) begin
        if (!m_armed) begin
          if (tgt != m_turbo) begin
            if (r_crst) begin
              m_cval = tgt; m_commit = c + 1; m_fz_start = c + 1; m_fz_end = c + 1 + SETTLE;
            end else begin
              m_armed = 1'b1; m_arm_start = c + 1;
            end
          end
        end else if (tgt == m_turbo) begin
          m_armed = 1'b0;
        end else if ((r_ck && r_m1 && r_mreq) || (c - m_arm_start == ATO) || r_crst) begin
          m_armed = 1'b0; m_cval = tgt; m_commit = c + 3;
          m_fz_start = c + 1; m_fz_end = c + 3 + SETTLE;
        end
      end
      // Frames elapsed since the last force request, capped at the hold length.
      if (r_frc != '0) m_fs = 0;
      else if (r_tick && m_fs < HOLD) m_fs = m_fs + 1;
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
